// File: rtl/mc_control.sv
// Multicycle MIPS-subset control unit: a Moore FSM that steps each instruction
// through fetch, decode and execute states and decodes the datapath strobes
// from the registered state. Supports lw, sw, R-type, beq, addi and j.
module mc_control (
  input  logic       clk,
  input  logic       reset,     // asynchronous, active-low
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite, w_branch;
  logic       w_iord, w_memread, w_memwrite, w_irwrite, w_regwrite;
  logic       w_regdst, w_memtoreg, w_alusrca;
  logic [1:0] w_alusrcb, w_aluop, w_pcsrc;
  logic       w_retire, w_illegal;

  // State register; reset parks the machine in FETCH.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state selection and Moore output decode of the registered state.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_iord     = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluop    = 2'b00;
    w_pcsrc    = 2'b00;
    w_retire   = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_next    = S_DECODE;
        w_memread = 1'b1;
        w_irwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_pcwrite = 1'b1;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;  // precompute branch target into ALUOut
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            // PC already advanced in FETCH, so just resume at the next instruction.
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_next    = S_MEMWB;
        w_iord    = 1'b1;
        w_memread = 1'b1;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_EXECUTE: begin
        w_next    = S_ALUWB;
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
        w_retire  = 1'b1;
      end
      S_ADDIEX: begin
        w_next    = S_ADDIWB;
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_retire  = 1'b1;
      end
      default: w_next = S_FETCH;  // unused encodings recover to FETCH
    endcase
  end

  // Outputs are qualified by reset so that asserting it silences every strobe
  // immediately, without waiting for the state register to settle on a clock.
  assign pcen     = (w_pcwrite | (w_branch & zero)) & reset;
  assign iord     = w_iord     & reset;
  assign memread  = w_memread  & reset;
  assign memwrite = w_memwrite & reset;
  assign irwrite  = w_irwrite  & reset;
  assign regwrite = w_regwrite & reset;
  assign regdst   = w_regdst   & reset;
  assign memtoreg = w_memtoreg & reset;
  assign alusrca  = w_alusrca  & reset;
  assign alusrcb  = w_alusrcb  & {2{reset}};
  assign aluop    = w_aluop    & {2{reset}};
  assign pcsrc    = w_pcsrc    & {2{reset}};
  assign retire   = w_retire   & reset;
  assign illegal  = w_illegal  & reset;
  assign state    = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a cycle-by-cycle vector table covering every
// instruction class, plus hand sequences for reset behaviour.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       pcen, iord, memread, memwrite, irwrite, regwrite;
  logic       regdst, memtoreg, alusrca, retire, illegal;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state;

  int n_pass  = 0;
  int n_total = 0;

  mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .pcen(pcen), .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .retire(retire), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  // Output bundle layout (21 bits, MSB first):
  // pcen iord memread memwrite irwrite regwrite regdst memtoreg alusrca
  // alusrcb[1:0] aluop[1:0] pcsrc[1:0] retire illegal state[3:0]
  function automatic logic [20:0] outs();
    return {pcen, iord, memread, memwrite, irwrite, regwrite, regdst,
            memtoreg, alusrca, alusrcb, aluop, pcsrc, retire, illegal, state};
  endfunction

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        z;
    logic [20:0] exp;
  } vec_t;

  //                           p i r w I R d m a  sb  op  pc r l state
  localparam logic [20:0] E_FETCH  = 21'b1_0_1_0_1_0_0_0_0_01_00_00_0_0_0000;
  localparam logic [20:0] E_DEC    = 21'b0_0_0_0_0_0_0_0_0_11_00_00_0_0_0001;
  localparam logic [20:0] E_DECILL = 21'b0_0_0_0_0_0_0_0_0_11_00_00_0_1_0001;
  localparam logic [20:0] E_MEMADR = 21'b0_0_0_0_0_0_0_0_1_10_00_00_0_0_0010;
  localparam logic [20:0] E_MEMRD  = 21'b0_1_1_0_0_0_0_0_0_00_00_00_0_0_0011;
  localparam logic [20:0] E_MEMWB  = 21'b0_0_0_0_0_1_0_1_0_00_00_00_1_0_0100;
  localparam logic [20:0] E_MEMWR  = 21'b0_1_0_1_0_0_0_0_0_00_00_00_1_0_0101;
  localparam logic [20:0] E_EXEC   = 21'b0_0_0_0_0_0_0_0_1_00_10_00_0_0_0110;
  localparam logic [20:0] E_ALUWB  = 21'b0_0_0_0_0_1_1_0_0_00_00_00_1_0_0111;
  localparam logic [20:0] E_BRT    = 21'b1_0_0_0_0_0_0_0_1_00_01_01_1_0_1000;
  localparam logic [20:0] E_BRNT   = 21'b0_0_0_0_0_0_0_0_1_00_01_01_1_0_1000;
  localparam logic [20:0] E_ADDIEX = 21'b0_0_0_0_0_0_0_0_1_10_00_00_0_0_1001;
  localparam logic [20:0] E_ADDIWB = 21'b0_0_0_0_0_1_0_0_0_00_00_00_1_0_1010;
  localparam logic [20:0] E_JUMP   = 21'b1_0_0_0_0_0_0_0_0_00_00_10_1_0_1011;
  localparam logic [20:0] E_ZERO   = 21'b0;

  vec_t vecs[$];

  initial begin
    // One row per clock cycle, applied back to back starting in FETCH.
    // Opcodes in FETCH and non-sampling states are deliberately junk.
    vecs = '{
      '{"lw.fetch",     6'b111111, 1'b0, E_FETCH },
      '{"lw.decode",    6'b100011, 1'b0, E_DEC   },
      '{"lw.memadr",    6'b100011, 1'b0, E_MEMADR},
      '{"lw.memrd",     6'b000010, 1'b0, E_MEMRD },
      '{"lw.memwb",     6'b101011, 1'b1, E_MEMWB },
      '{"beqT.fetch",   6'b000000, 1'b1, E_FETCH },
      '{"beqT.decode",  6'b000100, 1'b1, E_DEC   },
      '{"beqT.branch",  6'b000100, 1'b1, E_BRT   },
      '{"beqN.fetch",   6'b000100, 1'b0, E_FETCH },
      '{"beqN.decode",  6'b000100, 1'b0, E_DEC   },
      '{"beqN.branch",  6'b000100, 1'b0, E_BRNT  },
      '{"sw.fetch",     6'b100011, 1'b0, E_FETCH },
      '{"sw.decode",    6'b101011, 1'b0, E_DEC   },
      '{"sw.memadr",    6'b101011, 1'b0, E_MEMADR},
      '{"sw.memwr",     6'b100011, 1'b1, E_MEMWR },
      '{"ill.fetch",    6'b000000, 1'b0, E_FETCH },
      '{"ill.decode",   6'b111111, 1'b0, E_DECILL},
      '{"r.fetch",      6'b111111, 1'b0, E_FETCH },
      '{"r.decode",     6'b000000, 1'b0, E_DEC   },
      '{"r.execute",    6'b101011, 1'b1, E_EXEC  },
      '{"r.aluwb",      6'b111111, 1'b1, E_ALUWB },
      '{"j.fetch",      6'b000010, 1'b0, E_FETCH },
      '{"j.decode",     6'b000010, 1'b0, E_DEC   },
      '{"j.jump",       6'b000100, 1'b1, E_JUMP  },
      '{"addi.fetch",   6'b000010, 1'b0, E_FETCH },
      '{"addi.decode",  6'b001000, 1'b0, E_DEC   },
      '{"addi.ex",      6'b000010, 1'b0, E_ADDIEX},
      '{"addi.wb",      6'b111111, 1'b0, E_ADDIWB},
      '{"lw2.fetch",    6'b100011, 1'b0, E_FETCH }
    };

    // Reset asserted: everything, including FETCH strobes, must read 0.
    reset  = 1'b0;
    opcode = 6'b111111;
    zero   = 1'b1;
    #2 check("reset.idle", outs(), E_ZERO);
    @(negedge clk);
    #1 check("reset.held", outs(), E_ZERO);

    // Release on a falling edge; the first row is checked in the same half-cycle.
    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      zero   = vecs[i].z;
      #1 check(vecs[i].name, outs(), vecs[i].exp);
      @(negedge clk);
    end

    // Now in DECODE of a lw; walk it into MEMRD and abort with reset.
    @(negedge clk);              // MEMADR
    @(negedge clk);              // MEMRD
    #1 check("abort.memrd", outs(), E_MEMRD);
    #1 reset = 1'b0;             // mid-cycle, well away from any clock edge
    #1 check("abort.async", outs(), E_ZERO);
    @(posedge clk);
    #1 check("abort.held", outs(), E_ZERO);

    @(negedge clk);
    reset = 1'b1;
    #1 check("abort.release", outs(), E_FETCH);
    @(negedge clk);
    #1 check("abort.decode", outs(), E_DEC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
